// File: rtl/memory_input_ports.sv
// rtl/memory_input_ports.sv - memory-mapped input ports with status register and irq
// Four peripheral-pushed byte ports plus a status byte, read by the CPU with 1-cycle latency.
module memory_input_ports #(
   parameter int MEMORY_ADDRESS_BITS = 8,
   parameter int MEMORY_DATA_BITS    = 8,
   parameter int PORT_BASE           = 'hfc
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rd_mem_en,
   input  logic [MEMORY_ADDRESS_BITS-1:0] rd_mem_addr,
   output logic                           rd_io_hit,
   output logic [MEMORY_DATA_BITS-1:0]    rd_io_data,
   output logic                           rd_io_valid,
   input  logic [MEMORY_DATA_BITS-1:0]    in_port0,
   input  logic [MEMORY_DATA_BITS-1:0]    in_port1,
   input  logic [MEMORY_DATA_BITS-1:0]    in_port2,
   input  logic [MEMORY_DATA_BITS-1:0]    in_port3,
   input  logic                           in_port0_write_en,
   input  logic                           in_port1_write_en,
   input  logic                           in_port2_write_en,
   input  logic                           in_port3_write_en,
   output logic                           irq
);
   localparam int AW = MEMORY_ADDRESS_BITS;
   localparam int DW = MEMORY_DATA_BITS;
   localparam logic [AW-1:0] STATUS_ADDR = AW'(PORT_BASE - 1);

   logic [3:0][DW-1:0] in_data;
   logic [3:0]         push;
   logic [3:0]         port_rd;
   logic               status_rd;

   logic [3:0][DW-1:0] held_q, held_d;
   logic [3:0]         full_q, full_d;
   logic [3:0]         ovf_q, ovf_d;
   logic [DW-1:0]      rd_data_q, rd_data_d;
   logic               valid_q;
   logic               irq_q;

   always_comb begin
      in_data   = {in_port3, in_port2, in_port1, in_port0};
      push      = {in_port3_write_en, in_port2_write_en, in_port1_write_en, in_port0_write_en};
      status_rd = rd_mem_en && (rd_mem_addr == STATUS_ADDR);
      for (int i = 0; i < 4; i++) begin
         port_rd[i] = rd_mem_en && (rd_mem_addr == AW'(PORT_BASE + i));
      end
   end

   assign rd_io_hit = status_rd | (|port_rd);

   always_comb begin
      held_d    = held_q;
      full_d    = full_q;
      // Status read clears overflow first so a same-cycle overflow set below wins.
      ovf_d     = status_rd ? 4'b0000 : ovf_q;
      rd_data_d = rd_data_q;
      for (int i = 0; i < 4; i++) begin
         if (push[i]) begin
            held_d[i] = in_data[i];
            full_d[i] = 1'b1;
            if (full_q[i] && !port_rd[i]) begin
               ovf_d[i] = 1'b1;
            end
         end else if (port_rd[i]) begin
            full_d[i] = 1'b0;
         end
         if (port_rd[i]) begin
            rd_data_d = held_q[i];
         end
      end
      if (status_rd) begin
         rd_data_d = DW'({ovf_q, full_q});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q    <= '0;
         full_q    <= '0;
         ovf_q     <= '0;
         rd_data_q <= '0;
         valid_q   <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         held_q    <= held_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         rd_data_q <= rd_data_d;
         valid_q   <= rd_io_hit;
         irq_q     <= |full_d;
      end
   end

   assign rd_io_data  = rd_data_q;
   assign rd_io_valid = valid_q;
   assign irq         = irq_q;
endmodule

// File: tb/tb_memory_input_ports.sv
// tb/tb_memory_input_ports.sv - testbench for memory_input_ports
// Directed vector table, randomized run against a reference model, and async-reset sequence.
module tb_memory_input_ports;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rd_mem_en = 1'b0;
   logic [7:0] rd_mem_addr = 8'h00;
   logic       rd_io_hit;
   logic [7:0] rd_io_data;
   logic       rd_io_valid;
   logic [7:0] in_port0 = 8'h00, in_port1 = 8'h00, in_port2 = 8'h00, in_port3 = 8'h00;
   logic       in_port0_write_en = 1'b0, in_port1_write_en = 1'b0;
   logic       in_port2_write_en = 1'b0, in_port3_write_en = 1'b0;
   logic       irq;

   int n_checks = 0;
   int n_err    = 0;

   memory_input_ports #(
      .MEMORY_ADDRESS_BITS(8),
      .MEMORY_DATA_BITS(8),
      .PORT_BASE('hfc)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rd_mem_en(rd_mem_en), .rd_mem_addr(rd_mem_addr),
      .rd_io_hit(rd_io_hit), .rd_io_data(rd_io_data), .rd_io_valid(rd_io_valid),
      .in_port0(in_port0), .in_port1(in_port1), .in_port2(in_port2), .in_port3(in_port3),
      .in_port0_write_en(in_port0_write_en), .in_port1_write_en(in_port1_write_en),
      .in_port2_write_en(in_port2_write_en), .in_port3_write_en(in_port3_write_en),
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [7:0]  addr;
      logic [3:0]  pm;
      logic [31:0] pd;
      logic        exp_hit;
      logic [7:0]  exp_data;
      logic        exp_valid;
      logic        exp_irq;
   } vec_t;

   vec_t vt[20];

   // Reference state: what each port holds, whether unread data is waiting, and whether data was lost.
   logic [7:0] m_held[4];
   bit         m_full[4];
   bit         m_ovf[4];
   logic [7:0] m_data;
   bit         m_valid;
   bit         m_irq;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] addr, input logic [3:0] pm,
                        input logic [31:0] pd, output logic hit, output logic [7:0] data,
                        output logic v, output logic q);
      rd_mem_en   = en;
      rd_mem_addr = addr;
      {in_port3, in_port2, in_port1, in_port0} = pd;
      {in_port3_write_en, in_port2_write_en, in_port1_write_en, in_port0_write_en} = pm;
      #1 hit = rd_io_hit;
      @(posedge clk);
      #1;
      data = rd_io_data;
      v    = rd_io_valid;
      q    = irq;
      rd_mem_en = 1'b0;
      {in_port3_write_en, in_port2_write_en, in_port1_write_en, in_port0_write_en} = 4'b0000;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_held[i] = 8'h00;
         m_full[i] = 0;
         m_ovf[i]  = 0;
      end
      m_data  = 8'h00;
      m_valid = 0;
      m_irq   = 0;
   endtask

   task automatic model_step(input logic en, input logic [7:0] addr, input logic [3:0] pm,
                             input logic [31:0] pd, output bit exp_hit);
      int  port;
      bit  clear_ovf;
      bit  any_full;
      port      = -1;
      clear_ovf = 0;
      exp_hit   = en && (int'(addr) >= 'hfb) && (int'(addr) <= 'hff);
      if (exp_hit) begin
         if (addr == 8'hfb) begin
            m_data    = {m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0],
                         m_full[3], m_full[2], m_full[1], m_full[0]};
            clear_ovf = 1;
         end else begin
            port   = int'(addr) - 'hfc;
            m_data = m_held[port];
         end
      end
      m_valid = exp_hit;
      if (clear_ovf) begin
         for (int i = 0; i < 4; i++) m_ovf[i] = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (pm[i]) begin
            if (m_full[i] && port != i) m_ovf[i] = 1;
            m_held[i] = pd[8*i +: 8];
            m_full[i] = 1;
         end else if (port == i) begin
            m_full[i] = 0;
         end
      end
      any_full = 0;
      for (int i = 0; i < 4; i++) any_full |= m_full[i];
      m_irq = any_full;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   initial begin
      logic       hit, v, q;
      logic [7:0] data;
      bit         exp_hit;
      logic       en;
      logic [7:0] addr;
      logic [3:0] pm;
      logic [31:0] pd;
      int         pick;

      vt[0]  = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h00, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 8'h00, 4'h4, 32'h005A0000, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[2]  = '{1'b1, 8'hfe, 4'h0, 32'h0,        1'b1, 8'h5A, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h00, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 4'h1, 32'h00000011, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[5]  = '{1'b0, 8'h00, 4'h1, 32'h00000022, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[6]  = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h11, 1'b1, 1'b1};
      vt[7]  = '{1'b1, 8'hfc, 4'h0, 32'h0,        1'b1, 8'h22, 1'b1, 1'b0};
      vt[8]  = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h00, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 8'h00, 4'h2, 32'h00003300, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[10] = '{1'b1, 8'hfd, 4'h2, 32'h00004400, 1'b1, 8'h33, 1'b1, 1'b1};
      vt[11] = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h02, 1'b1, 1'b1};
      vt[12] = '{1'b1, 8'hfd, 4'h0, 32'h0,        1'b1, 8'h44, 1'b1, 1'b0};
      vt[13] = '{1'b0, 8'h00, 4'h8, 32'h77000000, 1'b0, 8'h44, 1'b0, 1'b1};
      vt[14] = '{1'b1, 8'hfb, 4'h8, 32'h88000000, 1'b1, 8'h08, 1'b1, 1'b1};
      vt[15] = '{1'b1, 8'hfb, 4'h0, 32'h0,        1'b1, 8'h88, 1'b1, 1'b1};
      vt[16] = '{1'b1, 8'hff, 4'h0, 32'h0,        1'b1, 8'h88, 1'b1, 1'b0};
      vt[17] = '{1'b1, 8'hff, 4'h0, 32'h0,        1'b1, 8'h88, 1'b1, 1'b0};
      vt[18] = '{1'b0, 8'hfc, 4'h0, 32'h0,        1'b0, 8'h88, 1'b0, 1'b0};
      vt[19] = '{1'b1, 8'h10, 4'h0, 32'h0,        1'b0, 8'h88, 1'b0, 1'b0};

      #1;
      chk("reset_data", rd_io_data, 0);
      chk("reset_valid", rd_io_valid, 0);
      chk("reset_irq", irq, 0);
      do_reset();

      for (int k = 0; k < 20; k++) begin
         drive(vt[k].en, vt[k].addr, vt[k].pm, vt[k].pd, hit, data, v, q);
         chk($sformatf("vec%0d_hit", k), hit, vt[k].exp_hit);
         chk($sformatf("vec%0d_data", k), data, vt[k].exp_data);
         chk($sformatf("vec%0d_valid", k), v, vt[k].exp_valid);
         chk($sformatf("vec%0d_irq", k), q, vt[k].exp_irq);
      end

      do_reset();
      for (int k = 0; k < 400; k++) begin
         en   = ($urandom_range(0, 3) != 0);
         pick = $urandom_range(0, 9);
         addr = (pick < 7) ? 8'(8'hf9 + pick) : 8'($urandom);
         pm   = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         pd   = $urandom;
         model_step(en, addr, pm, pd, exp_hit);
         drive(en, addr, pm, pd, hit, data, v, q);
         chk($sformatf("rnd%0d_hit", k), hit, exp_hit);
         chk($sformatf("rnd%0d_data", k), data, m_data);
         chk($sformatf("rnd%0d_valid", k), v, m_valid);
         chk($sformatf("rnd%0d_irq", k), q, m_irq);
      end

      // Fill every port, read one, then drop reset mid-cycle.
      drive(1'b0, 8'h00, 4'hf, 32'hA1B2C3D4, hit, data, v, q);
      chk("fill_irq", q, 1);
      drive(1'b1, 8'hfc, 4'h0, 32'h0, hit, data, v, q);
      chk("fill_read_data", data, 8'hD4);
      chk("fill_read_irq", q, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_data", rd_io_data, 0);
      chk("async_rst_valid", rd_io_valid, 0);
      chk("async_rst_irq", irq, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, 8'hfc, 4'h0, 32'h0, hit, data, v, q);
      chk("post_rst_port0", data, 8'h00);
      chk("post_rst_valid", v, 1);
      chk("post_rst_irq", q, 0);
      drive(1'b1, 8'hfb, 4'h0, 32'h0, hit, data, v, q);
      chk("post_rst_status", data, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
